ov7670_capture: RTL and testbench

- Upstream stage of the image-processing chain. Takes the raw OV7670 parallel byte stream (PCLK/VSYNC/HREF/D[7:0]) and turns it into RGB565 pixel writes, each with a linear frame-buffer address.
- Its write-port outputs (we_out, wAddr_out, wData_out) connect directly to the filter stages' we_in/wAddr_in/wData_in.
- Camera signals are oversampled in the clk domain. cam_pclk is never used as a clock.

---
 rtl/ov7670_cap_pkg.sv | 27 ++
 rtl/ov7670_capture_if.sv | 25 ++
 rtl/ov7670_capture_cam_sig_sync.sv | 33 +++
 rtl/ov7670_capture.sv | 185 ++++++++++++++++++
 tb/tb_ov7670_capture.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_cap_pkg.sv
// Shared types and constants for the OV7670 capture front end.
// Default geometry is QVGA; the top may be built for other sizes.
package ov7670_cap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      VS_HIGH = 2'd2,
      FRAME   = 2'd3
   } state_t;

   localparam int ERR_LINE = 0;
   localparam int ERR_OVF  = 1;

   localparam int DEF_WIDTH  = 320;
   localparam int DEF_HEIGHT = 240;
   localparam int NUM_PIXELS = DEF_WIDTH * DEF_HEIGHT;
   localparam int ADDR_W     = $clog2(NUM_PIXELS);
   localparam int PIX_W      = 16;

   // Camera sends RGB565 high byte first.
   function automatic logic [PIX_W-1:0] rgb565(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
      return {first_byte, second_byte};
   endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Pixel write port and frame status from the capture block to the filter chain.
// we_out is a one-cycle valid strobe with no ready: the consumer must accept every write.
interface ov7670_capture_if;
   import ov7670_cap_pkg::*;

   logic              we_out;
   logic [ADDR_W-1:0] wAddr_out;
   logic [PIX_W-1:0]  wData_out;
   logic              frame_start;
   logic              frame_done;
   logic              frame_ok;
   logic [1:0]        err;
   state_t            state;

   modport master (
      output we_out, wAddr_out, wData_out,
      output frame_start, frame_done, frame_ok, err, state
   );

   modport slave (
      input we_out, wAddr_out, wData_out,
      input frame_start, frame_done, frame_ok, err, state
   );

endinterface

// File: rtl/ov7670_capture_cam_sig_sync.sv
// N-stage synchronizer with a previous-sample register and edge outputs.
// All camera inputs use the same depth so their samples stay aligned.
module cam_sig_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] sr [STAGES];
   logic [W-1:0] prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) sr[i] <= '0;
         prev <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
         prev <= sr[STAGES-1];
      end
   end

   assign q    = sr[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: oversamples PCLK/VSYNC/HREF/D in the clk domain
// and emits RGB565 pixel writes with linear frame-buffer addresses.
module ov7670_capture
   import ov7670_cap_pkg::*;
#(
   parameter int IMG_WIDTH   = DEF_WIDTH,
   parameter int IMG_HEIGHT  = DEF_HEIGHT,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   ov7670_capture_if.master  wr
);

   localparam int                NPIX   = IMG_WIDTH * IMG_HEIGHT;
   localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(NPIX);
   // Two extra bits so over-long frames keep counting without wrapping.
   localparam int                CNT_W  = ADDR_W + 2;

   logic       pclk_q, pclk_rise, pclk_fall;
   logic       vs_q, vs_rise, vs_fall;
   logic       href_q, href_rise, href_fall;
   logic [7:0] data_q, data_rise, data_fall;
   logic       unused_sync;

   cam_sig_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_pclk (
      .clk(clk), .reset(reset), .d(cam_pclk),
      .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall)
   );

   cam_sig_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_vsync (
      .clk(clk), .reset(reset), .d(cam_vsync),
      .q(vs_q), .rise(vs_rise), .fall(vs_fall)
   );

   cam_sig_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_href (
      .clk(clk), .reset(reset), .d(cam_href),
      .q(href_q), .rise(href_rise), .fall(href_fall)
   );

   cam_sig_sync #(.W(8), .STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .reset(reset), .d(cam_data),
      .q(data_q), .rise(data_rise), .fall(data_fall)
   );

   assign unused_sync = ^{pclk_q, pclk_fall, vs_q, data_rise, data_fall};

   state_t             state;
   logic               phase;
   logic [7:0]         hi_byte;
   logic               pix_valid;
   logic [PIX_W-1:0]   pix_data;
   logic [ADDR_W-1:0]  addr;
   logic [CNT_W-1:0]   line_cnt;
   logic [CNT_W-1:0]   pix_cnt;
   logic [1:0]         err;
   logic               we;
   logic [ADDR_W-1:0]  waddr;
   logic [PIX_W-1:0]   wdata;
   logic               fstart;
   logic               fdone;
   logic               fok;

   logic               capture;
   logic               phase_eff;
   logic               write_ok;
   logic [CNT_W-1:0]   line_cnt_eff;
   logic [CNT_W-1:0]   pix_cnt_nxt;
   logic [1:0]         err_nxt;

   always_comb begin
      capture   = (state == FRAME) && pclk_rise && href_q;
      phase_eff = href_rise ? 1'b0 : phase;
      write_ok  = pix_valid && (addr < NPIX_A);
      // A pixel still in the write stage belongs to the line that is ending.
      line_cnt_eff = line_cnt + CNT_W'(pix_valid);
      pix_cnt_nxt  = pix_cnt + CNT_W'(pix_valid);
      err_nxt = err;
      if (pix_valid && !write_ok)
         err_nxt[ERR_OVF] = 1'b1;
      if ((state == FRAME) && href_fall &&
          ((line_cnt_eff != CNT_W'(IMG_WIDTH)) || phase))
         err_nxt[ERR_LINE] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= 1'b0;
         hi_byte   <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
         addr      <= '0;
         line_cnt  <= '0;
         pix_cnt   <= '0;
         err       <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         fstart    <= 1'b0;
         fdone     <= 1'b0;
         fok       <= 1'b0;
      end else begin
         we        <= 1'b0;
         fstart    <= 1'b0;
         fdone     <= 1'b0;
         fok       <= 1'b0;
         pix_valid <= 1'b0;
         err       <= err_nxt;

         // Write stage: addr holds once the buffer is full, counts keep going.
         if (pix_valid) begin
            line_cnt <= line_cnt + CNT_W'(1);
            pix_cnt  <= pix_cnt_nxt;
            if (write_ok) begin
               we    <= 1'b1;
               waddr <= addr;
               wdata <= pix_data;
               addr  <= addr + ADDR_W'(1);
            end
         end

         if (state == FRAME) begin
            if (href_rise) begin
               phase    <= 1'b0;
               line_cnt <= '0;
            end
            if (capture) begin
               if (!phase_eff) begin
                  hi_byte <= data_q;
                  phase   <= 1'b1;
               end else begin
                  pix_valid <= 1'b1;
                  pix_data  <= rgb565(hi_byte, data_q);
                  phase     <= 1'b0;
               end
            end
         end

         case (state)
            IDLE: begin
               if (enable) state <= WAIT_VS;
            end
            WAIT_VS: begin
               if (vs_rise) state <= VS_HIGH;
            end
            VS_HIGH: begin
               if (vs_fall) begin
                  state    <= FRAME;
                  addr     <= '0;
                  err      <= '0;
                  pix_cnt  <= '0;
                  line_cnt <= '0;
                  phase    <= 1'b0;
                  fstart   <= 1'b1;
               end
            end
            FRAME: begin
               // enable only matters here, so a started frame always completes.
               if (vs_rise) begin
                  fdone <= 1'b1;
                  fok   <= (pix_cnt_nxt == CNT_W'(NPIX)) && (err_nxt == 2'b00);
                  state <= enable ? VS_HIGH : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wr.we_out      = we;
   assign wr.wAddr_out   = waddr;
   assign wr.wData_out   = wdata;
   assign wr.frame_start = fstart;
   assign wr.frame_done  = fdone;
   assign wr.frame_ok    = fok;
   assign wr.err         = err;
   assign wr.state       = state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 16x8 frame with PCLK at clk/4.
// Frame scenarios come from a table; reset and enable corner cases are hand-written.
module tb_ov7670_capture;
   import ov7670_cap_pkg::*;

   localparam int W     = 16;
   localparam int H     = 8;
   localparam int SS    = 2;
   localparam int NPIX  = W * H;
   localparam int LAT   = SS + 2;
   localparam int EXP_W = 32 + ADDR_W + PIX_W;

   localparam int PAT_IDX  = 0;
   localparam int PAT_F81F = 1;
   localparam int PAT_RND  = 2;

   typedef struct {
      int         n_lines;
      int         bad_line;
      int         bad_npix;
      bit         bad_stray;
      int         pat;
      bit         exp_ok;
      logic [1:0] exp_err;
   } row_t;

   // clock / reset
   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       cam_pclk;
   logic       cam_vsync;
   logic       cam_href;
   logic [7:0] cam_data;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ov7670_capture_if wr();

   ov7670_capture #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .wr(wr)
   );

   // scoreboard state
   int               errors = 0;
   int               checks = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [2:0]       fd_q[$];
   logic [EXP_W-1:0] e;
   logic [2:0]       f;
   bit               model_on = 1'b0;
   int               model_addr = 0;
   int               pix_idx = 0;
   bit               fd_pending = 1'b0;
   logic [2:0]       fd_val;
   row_t             tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // driver tasks
   function automatic logic [15:0] pix_val(input int pat, input int idx);
      if (pat == PAT_IDX) return idx[15:0];
      if (pat == PAT_F81F && idx == 0) return 16'hF81F;
      return 16'($urandom_range(0, 65535));
   endfunction

   task automatic send_byte(input logic [7:0] b);
      cam_pclk = 1'b0;
      cam_data = b;
      tick(2);
      cam_pclk = 1'b1;
      tick(2);
   endtask

   task automatic send_pixel(input logic [15:0] v);
      send_byte(v[15:8]);
      cam_pclk = 1'b0;
      cam_data = v[7:0];
      tick(2);
      cam_pclk = 1'b1;
      if (model_on && model_addr < NPIX) begin
         exp_q.push_back({32'(cyc + LAT), ADDR_W'(model_addr), v});
         model_addr++;
      end
      tick(2);
   endtask

   task automatic send_line(input int npix, input bit stray, input int pat);
      cam_href = 1'b1;
      tick(2);
      for (int p = 0; p < npix; p++) begin
         send_pixel(pix_val(pat, pix_idx));
         pix_idx++;
      end
      if (stray) send_byte(8'hAA);
      cam_pclk = 1'b0;
      tick(2);
      cam_href = 1'b0;
      tick(4);
   endtask

   task automatic vsync_pulse(input bit next_on);
      if (fd_pending) begin
         fd_q.push_back(fd_val);
         fd_pending = 1'b0;
      end
      cam_vsync = 1'b1;
      tick(4);
      cam_vsync = 1'b0;
      model_on   = next_on;
      model_addr = 0;
      pix_idx    = 0;
      tick(4);
   endtask

   task automatic end_frame(input bit ok, input logic [1:0] err);
      if (model_on) begin
         fd_pending = 1'b1;
         fd_val     = {ok, err};
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_we"},    64'(wr.we_out),      64'd0);
      check({tag, "_addr"},  64'(wr.wAddr_out),   64'd0);
      check({tag, "_data"},  64'(wr.wData_out),   64'd0);
      check({tag, "_start"}, 64'(wr.frame_start), 64'd0);
      check({tag, "_done"},  64'(wr.frame_done),  64'd0);
      check({tag, "_ok"},    64'(wr.frame_ok),    64'd0);
      check({tag, "_err"},   64'(wr.err),         64'd0);
      check({tag, "_state"}, 64'(wr.state),       64'(IDLE));
   endtask

   // monitor: compare DUT outputs against the expected queues
   always @(negedge clk) begin
      if (wr.we_out) begin
         check("write_expected", 64'(exp_q.size() > 0), 64'd1);
         check("addr_in_range", 64'(wr.wAddr_out < NPIX), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_addr", 64'(wr.wAddr_out), 64'(e[PIX_W +: ADDR_W]));
            check("write_data", 64'(wr.wData_out), 64'(e[PIX_W-1:0]));
            check("write_latency", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
         end
      end
      if (wr.frame_done) begin
         check("frame_done_expected", 64'(fd_q.size() > 0), 64'd1);
         if (fd_q.size() > 0) begin
            f = fd_q.pop_front();
            check("frame_ok", 64'(wr.frame_ok), 64'(f[2]));
            check("frame_err", 64'(wr.err), 64'(f[1:0]));
         end
      end
      if (wr.frame_start) check("err_clear_at_start", 64'(wr.err), 64'd0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // frame scenarios: lines, bad line index, its pixel count, stray byte, pattern, ok, err
      tbl[0] = '{H,     -1, W,     1'b0, PAT_IDX,  1'b1, 2'b00};
      tbl[1] = '{H,     -1, W,     1'b0, PAT_F81F, 1'b1, 2'b00};
      tbl[2] = '{H,      3, W - 1, 1'b0, PAT_RND,  1'b0, 2'b01};
      tbl[3] = '{H,      5, W,     1'b1, PAT_RND,  1'b0, 2'b01};
      tbl[4] = '{H + 1, -1, W,     1'b0, PAT_RND,  1'b0, 2'b10};
      tbl[5] = '{H,     -1, W,     1'b0, PAT_RND,  1'b1, 2'b00};

      reset = 1'b1; enable = 1'b0;
      cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      tick(3);
      check_cleared("reset");
      reset = 1'b0;
      tick(3);
      check("idle_without_enable", 64'(wr.state), 64'(IDLE));
      enable = 1'b1;
      tick(2);
      check("wait_vs_after_enable", 64'(wr.state), 64'(WAIT_VS));

      for (int r = 0; r < 6; r++) begin
         vsync_pulse(1'b1);
         for (int l = 0; l < tbl[r].n_lines; l++) begin
            if (l == tbl[r].bad_line)
               send_line(tbl[r].bad_npix, tbl[r].bad_stray, tbl[r].pat);
            else
               send_line(W, 1'b0, tbl[r].pat);
         end
         end_frame(tbl[r].exp_ok, tbl[r].exp_err);
      end

      // enable dropped mid-frame: frame completes, then capture stops
      vsync_pulse(1'b1);
      for (int l = 0; l < H; l++) begin
         if (l == 4) enable = 1'b0;
         send_line(W, 1'b0, PAT_RND);
      end
      end_frame(1'b1, 2'b00);
      vsync_pulse(1'b0);
      check("idle_after_enable_drop", 64'(wr.state), 64'(IDLE));
      for (int l = 0; l < H; l++) send_line(W, 1'b0, PAT_RND);
      vsync_pulse(1'b0);
      check("still_idle_when_disabled", 64'(wr.state), 64'(IDLE));

      // reset asserted in the middle of a line
      enable = 1'b1;
      tick(4);
      vsync_pulse(1'b1);
      cam_href = 1'b1;
      tick(2);
      for (int p = 0; p < 3; p++) send_pixel(pix_val(PAT_RND, p));
      tick(6);
      reset = 1'b1;
      tick(1);
      check_cleared("midline_reset");
      model_on = 1'b0;
      send_pixel(16'h1234);
      reset = 1'b0;
      send_pixel(16'h5678);
      send_pixel(16'h9ABC);
      cam_pclk = 1'b0;
      tick(2);
      cam_href = 1'b0;
      tick(4);
      check("wait_vs_after_reset", 64'(wr.state), 64'(WAIT_VS));
      vsync_pulse(1'b1);
      for (int l = 0; l < H; l++) send_line(W, 1'b0, PAT_RND);
      end_frame(1'b1, 2'b00);
      enable = 1'b0;
      vsync_pulse(1'b0);

      for (int k = 0; k < 100 && (exp_q.size() > 0 || fd_q.size() > 0); k++) tick(1);
      check("writes_drained", 64'(exp_q.size()), 64'd0);
      check("frames_drained", 64'(fd_q.size()), 64'd0);
      check("final_state_idle", 64'(wr.state), 64'(IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
